// File: rtl/logs_pwm_decoder.sv
// logs_pwm_decoder
// Recovers sample-rate amplitude from the 1-bit PWM stream of the square-wave
// mixer. High cycles are counted over fixed 2^DEC_LOG2-cycle windows. The last
// 2^AVG_LOG2 window counts are summed as a moving sum. Each sum is handed to a
// small FIFO with a valid/ready handshake.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous reset, active-low
//   pwm_in        PWM audio, asynchronous to clk (synchronized internally)
//   enable        run the decimator; low holds it idle (FIFO is kept)
//   sample_out    FIFO head sample, W = DEC_LOG2 + 1 + AVG_LOG2 bits
//   sample_valid  FIFO non-empty
//   sample_ready  consumer accepts the head sample
//   overflow_cnt  saturating count of samples dropped on a full FIFO
//   clear_ovf     synchronous clear of overflow_cnt (wins over a same-cycle drop)
module logs_pwm_decoder #(
   parameter int DEC_LOG2   = 8,
   parameter int AVG_LOG2   = 2,
   parameter int FIFO_DEPTH = 4,
   localparam int W         = DEC_LOG2 + 1 + AVG_LOG2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pwm_in,
   input  logic         enable,
   output logic [W-1:0] sample_out,
   output logic         sample_valid,
   input  logic         sample_ready,
   output logic [7:0]   overflow_cnt,
   input  logic         clear_ovf
);

   localparam int NWIN   = 1 << AVG_LOG2;
   localparam int CW     = DEC_LOG2 + 1;
   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int CNTW   = PW + 1;
   localparam int WARM_W = AVG_LOG2 + 1;

   logic                sync1_q, sync1_d, sync2_q, sync2_d;
   logic [DEC_LOG2-1:0] win_cnt_q, win_cnt_d;
   logic [CW-1:0]       acc_q, acc_d;
   logic [CW-1:0]       hist_q [NWIN];
   logic [CW-1:0]       hist_d [NWIN];
   logic [W-1:0]        sum_q, sum_d;
   logic [WARM_W-1:0]   warm_q, warm_d;
   logic                push_pend_q, push_pend_d;
   logic [W-1:0]        mem_q [FIFO_DEPTH];
   logic [W-1:0]        mem_d [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]     count_q, count_d;
   logic [7:0]          ovf_q, ovf_d;

   logic          s;
   logic          win_last;
   logic [CW-1:0] c;
   logic          full, pop, push_req, push, drop;
   logic [PW-1:0] rd_prev;

   assign s        = sync2_q;
   assign win_last = (win_cnt_q == '1);
   assign c        = acc_q + CW'(s);

   always_comb begin
      sync1_d     = pwm_in;
      sync2_d     = sync1_q;
      win_cnt_d   = win_cnt_q;
      acc_d       = acc_q;
      hist_d      = hist_q;
      sum_d       = sum_q;
      warm_d      = warm_q;
      push_pend_d = 1'b0;

      if (!enable) begin
         win_cnt_d = '0;
         acc_d     = '0;
         sum_d     = '0;
         warm_d    = '0;
         for (int i = 0; i < NWIN; i++) hist_d[i] = '0;
      end else begin
         win_cnt_d = win_cnt_q + 1'b1;
         if (win_last) begin
            acc_d     = '0;
            hist_d[0] = c;
            for (int i = 1; i < NWIN; i++) hist_d[i] = hist_q[i-1];
            // running sum stays non-negative, so modular W-bit math is exact
            sum_d = sum_q + W'(c) - W'(hist_q[NWIN-1]);
            if (warm_q != WARM_W'(NWIN)) warm_d = warm_q + 1'b1;
            push_pend_d = (warm_q >= WARM_W'(NWIN - 1));
         end else begin
            acc_d = acc_q + CW'(s);
         end
      end
   end

   // A push pending on the cycle enable drops is cancelled, not delivered.
   assign full     = (count_q == CNTW'(FIFO_DEPTH));
   assign pop      = (count_q != '0) && sample_ready;
   assign push_req = push_pend_q && enable;
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNTW'(push) - CNTW'(pop);
      ovf_d    = ovf_q;
      if (push) begin
         mem_d[wr_ptr_q] = sum_q;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (clear_ovf) ovf_d = '0;
      else if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
   end

   // When empty, show the last popped entry: its slot cannot be rewritten
   // until the next push, which makes the FIFO non-empty again.
   assign rd_prev      = rd_ptr_q - PW'(1);
   assign sample_valid = (count_q != '0);
   assign sample_out   = sample_valid ? mem_q[rd_ptr_q] : mem_q[rd_prev];
   assign overflow_cnt = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         win_cnt_q   <= '0;
         acc_q       <= '0;
         sum_q       <= '0;
         warm_q      <= '0;
         push_pend_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= '0;
         for (int i = 0; i < NWIN; i++) hist_q[i] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         win_cnt_q   <= win_cnt_d;
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         warm_q      <= warm_d;
         push_pend_q <= push_pend_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         hist_q      <= hist_d;
         mem_q       <= mem_d;
      end
   end

endmodule

// File: tb/tb_logs_pwm_decoder.sv
// Testbench for logs_pwm_decoder: a behavioural model turns each stimulus
// cycle into expected samples (windows of high counts, sum of the last four),
// which are queued in a scoreboard; a monitor compares the DUT FIFO head,
// valid flag and overflow count against it every cycle.
module tb_logs_pwm_decoder;

   localparam int W     = 11;
   localparam int WIN   = 256;
   localparam int NW    = 4;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         pwm_in = 1'b0;
   logic         enable = 1'b0;
   logic         sample_ready = 1'b1;
   logic         clear_ovf = 1'b0;
   logic [W-1:0] sample_out;
   logic         sample_valid;
   logic [7:0]   overflow_cnt;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int mode = 0;

   // model state
   int m_p1 = 0, m_p2 = 0;
   int m_pos = 0, m_cnt = 0;
   int m_wins[$];
   bit m_pend = 0;
   int m_pend_val = 0;
   int expq[$];
   int m_ovf = 0;

   always #5 clk = ~clk;

   logs_pwm_decoder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pwm_in       (pwm_in),
      .enable       (enable),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overflow_cnt (overflow_cnt),
      .clear_ovf    (clear_ovf)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor + model: runs mid-cycle, compares DUT state after the last edge,
   // then predicts what the coming edge does with the inputs now applied.
   always @(negedge clk) begin : model
      int  s, sum;
      bit  pop, full, drop;
      if (!rst_n) begin
         m_p1 = 0; m_p2 = 0; m_pos = 0; m_cnt = 0;
         m_wins.delete(); expq.delete();
         m_pend = 0; m_ovf = 0;
      end else begin
         check("valid", sample_valid, expq.size() > 0);
         if (expq.size() > 0) check("sample", sample_out, expq[0]);
         check("ovf", overflow_cnt, m_ovf);

         full = (expq.size() == DEPTH);
         pop  = (expq.size() > 0) && sample_ready;
         drop = 0;
         if (pop) void'(expq.pop_front());
         if (m_pend && enable) begin
            if (!full || pop) expq.push_back(m_pend_val);
            else drop = 1;
         end
         if (clear_ovf) m_ovf = 0;
         else if (drop && m_ovf < 255) m_ovf++;
         m_pend = 0;

         s = m_p2; m_p2 = m_p1; m_p1 = int'(pwm_in);
         if (!enable) begin
            m_pos = 0; m_cnt = 0; m_wins.delete();
         end else begin
            m_cnt += s;
            m_pos++;
            if (m_pos == WIN) begin
               m_wins.push_back(m_cnt);
               m_pos = 0; m_cnt = 0;
               if (m_wins.size() > NW) void'(m_wins.pop_front());
               if (m_wins.size() == NW) begin
                  sum = 0;
                  foreach (m_wins[i]) sum += m_wins[i];
                  m_pend = 1;
                  m_pend_val = sum;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      case (mode)
         0: pwm_in = 1'b1;
         1: pwm_in = cyc[0];
         2: pwm_in = (cyc % 4 == 0);
         default: pwm_in = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #200000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      pwm_in = 1'b1;
      @(posedge clk); #1;
      check("rst_valid", sample_valid, 0);
      check("rst_sample", sample_out, 0);
      check("rst_ovf", overflow_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // constant high, synchronizer primed before enable
      mode = 0; run(4);
      enable = 1'b1; run(8 * WIN);

      // alternating
      mode = 1; run(6 * WIN);

      // 25% duty then step to constant high
      enable = 1'b0; run(1);
      enable = 1'b1; mode = 2; run(8 * WIN);
      mode = 0; run(6 * WIN);

      // backpressure
      enable = 1'b0; run(3);
      sample_ready = 1'b0;
      enable = 1'b1; run(10 * WIN + 4);
      check("bp_ovf", overflow_cnt, 3);
      check("bp_full", sample_valid, 1);

      k = 0;
      while (!m_pend && k < 600) begin step(); k++; end
      check("drop_wait_ok", k < 600, 1);
      clear_ovf = 1'b1; run(1);
      clear_ovf = 1'b0; run(1);
      check("clr_ovf", overflow_cnt, 0);
      sample_ready = 1'b1; run(6);
      check("drained", sample_valid, 0);

      // enable glitch with two samples queued
      enable = 1'b0; run(2);
      sample_ready = 1'b0;
      enable = 1'b1; run(5 * WIN + 100);
      enable = 1'b0; run(1);
      enable = 1'b1; run(5 * WIN);
      sample_ready = 1'b1; run(8);

      // async reset with three entries queued
      enable = 1'b0; run(2);
      sample_ready = 1'b0;
      enable = 1'b1; run(6 * WIN + 10);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", sample_valid, 0);
      check("arst_sample", sample_out, 0);
      check("arst_ovf", overflow_cnt, 0);
      enable = 1'b0;
      run(3);
      rst_n = 1'b1; sample_ready = 1'b1;
      run(3);
      enable = 1'b1; run(6 * WIN);

      // random PWM and random backpressure
      mode = 3;
      for (int i = 0; i < 12 * WIN; i++) begin
         step();
         sample_ready = ($urandom_range(0, 3) != 0);
         clear_ovf    = ($urandom_range(0, 499) == 0);
      end
      clear_ovf = 1'b0;
      sample_ready = 1'b1; enable = 1'b0; run(20);
      check("final_empty", sample_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/logs_pwm_decoder.md
# logs_pwm_decoder

Recovers sample-rate audio amplitude from the 1-bit PWM stream produced by the square-wave mixer, the receiving end of the `snd` output. It counts high cycles over fixed decimation windows, then smooths them with a moving average over the last few windows. Samples are delivered through a small FIFO with a valid/ready handshake. It serves as the on-chip loopback checker for the sonifier and as a capture front end for test equipment.

## Interface
Parameters:
- `DEC_LOG2`, 8: window length is 2^DEC_LOG2 clock cycles.
- `AVG_LOG2`, 2: moving average over 2^AVG_LOG2 windows (sum, not divided).
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of two and at least 2.
- Derived: W = DEC_LOG2 + 1 + AVG_LOG2, the sample width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous reset, active-low.
- `pwm_in`  in  1  PWM audio; asynchronous to `clk`.
- `enable`  in  1  run the decimator; low holds the decimator in idle.
- `sample_out`  out  W  FIFO head sample.
- `sample_valid`  out  1  FIFO non-empty.
- `sample_ready`  in  1  consumer accepts the head sample.
- `overflow_cnt`  out  8  saturating count of samples dropped on a full FIFO.
- `clear_ovf`  in  1  synchronous clear of `overflow_cnt`.

## Operation
- **Input sync:** `pwm_in` passes through a 2-flop synchronizer. `s` denotes the synchronized bit.
- **Window:**
  - `win_cnt` (DEC_LOG2 bits) and `acc` (DEC_LOG2+1 bits) advance every cycle while `enable` is high; `acc += s`.
  - On the cycle where `win_cnt` = 2^DEC_LOG2−1, the completed count c = `acc` + `s` (range 0..2^DEC_LOG2) closes the window.
  - On that edge `acc` is zeroed and `win_cnt` wraps to 0.
- **Average:**
  - A history shift register holds the last 2^AVG_LOG2 window counts.
  - On window close, `sum <= sum + c − oldest`, c shifts in and oldest drops out.
  - Full scale is 2^(DEC_LOG2+AVG_LOG2), which fits in W bits.
- **Warm-up:** `warm` counts closed windows, 0..2^AVG_LOG2. The first 2^AVG_LOG2−1 closes update `sum` and the history but do not emit. Every close from the 2^AVG_LOG2-th onward emits.
- **Emit:** a one-cycle `push_pend` is set on an emitting close. On the next edge the updated `sum` is pushed into the FIFO.
- **FIFO:**
  - Push when not full.
  - Pop when `sample_valid` && `sample_ready`.
  - Push and pop in the same cycle while full: both succeed and occupancy is unchanged.
  - Push with FIFO full and no pop: the sample is dropped and `overflow_cnt` increments, saturating at 255.
- **Overflow clear:** `clear_ovf` clears `overflow_cnt`. If a drop occurs in the same cycle, the clear wins and the result is 0.
- **`enable` low:**
  - Zeroes `win_cnt`, `acc`, `sum`, history, `warm` and `push_pend`, so a pending push is cancelled.
  - FIFO contents are kept and remain drainable.
  - The synchronizer keeps running.

## Timing
- **Reset (`rst_n` low, async):** all state clears.
  - `sample_out`=0, `sample_valid`=0, `overflow_cnt`=0.
  - FIFO empty; synchronizer flops 0.
  - The first window starts on the first edge with `rst_n` and `enable` both high.
- **Input latency:** `s` at edge t equals `pwm_in` sampled at edge t−2.
- **Output latency:** `sample_valid` rises at the 2nd rising edge after the final cycle of an emitting window, provided the FIFO was empty.
- **Sample rate:** with `enable` held high, one sample every 2^DEC_LOG2 cycles. The first sample appears 2^(DEC_LOG2+AVG_LOG2) cycles plus latency after the start of enable.
- **Handshake:**
  - `sample_out` is stable while `sample_valid` is high and `sample_ready` is low.
  - `sample_out` advances to the next entry, or holds its value with `sample_valid` low, on the edge after a pop.
- **Reset mid-window:** the partial window is discarded with no emission.
- **Reset mid-operation:** the FIFO is emptied.

## Test plan
- **Constant high:** `pwm_in`=1, defaults → first sample 1024 after 4 windows, then one sample of 1024 every 256 cycles; `overflow_cnt`=0.
- **Alternating:** `pwm_in` toggling every cycle → every sample is 512.
- **Duty step:** 25% duty (1 of 4 cycles high) for 8 windows, then constant 1 → steady samples 256. After the step, the emitted sums follow 448, 640, 832 then hold at 1024. The first post-step window may be mixed because of the 2-cycle synchronizer delay; check the exact boundary value.
- **Backpressure:** `sample_ready`=0 for 10 windows → 7 samples emitted, 4 stored, `overflow_cnt`=3. Then:
  - raise `sample_ready` → 4 samples drain back to back;
  - pulse `clear_ovf` in the same cycle as a forced drop → `overflow_cnt`=0.
- **Enable glitch:** drop `enable` for 1 cycle mid-window with 2 samples queued → queue intact, warm-up restarts, next sample 4 windows later.
- **Async reset:** assert `rst_n`=0 between clock edges with the FIFO holding 3 entries → `sample_valid`, `sample_out` and `overflow_cnt` go to 0 immediately; after release the behaviour matches the constant-high test.
